tcdm_bank_arbiter_varlat: RTL and testbench
===========================================

Name: tcdm_bank_arbiter_varlat

Overview:
- Slave-side companion to the per-master address decoder of the variable-latency TCDM crossbar.
- Shares one variable-latency bank between NumIn masters using round-robin arbitration.
- Records the winning master ID of every accepted request in an in-order ID FIFO, and routes each bank response (vld/rdata) back to that master.
- Allows up to MaxOutstanding in-flight transactions per bank.

Parameters:
- NumIn, 4, number of requesting masters (>=1)
- ReqDataWidth, 32, request payload width (addr/wdata/be/we bundle)
- RespDataWidth, 32, response payload width
- MaxOutstanding, 2, ID FIFO depth = maximum accepted-but-unanswered transactions (>=1)
- LogNumIn, NumIn>1 ? $clog2(NumIn) : 1, master index width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_i  in  NumIn  request per master
- data_i  in  NumIn x ReqDataWidth  request payload per master
- gnt_o  out  NumIn  grant per master, one-hot or zero
- vld_o  out  NumIn  response valid per master, one-hot or zero
- rdata_o  out  NumIn x RespDataWidth  response data; rdata_i broadcast to all masters
- req_o  out  1  request to bank
- data_o  out  ReqDataWidth  payload of the winning master
- gnt_i  in  1  bank grant
- vld_i  in  1  bank response valid (in order, variable latency)
- rdata_i  in  RespDataWidth  bank response data
- outstanding_o  out  $clog2(MaxOutstanding+1)  current FIFO occupancy
- err_o  out  1  sticky: vld_i received with FIFO empty

Behaviour:
- State:
  - rr_ptr_q (LogNumIn bits)
  - ID FIFO: MaxOutstanding entries of LogNumIn bits, with rd/wr pointers and occupancy count_q
  - err_q
- Reset (rst_i=1 at posedge) sets rr_ptr_q=0, count_q=0, FIFO pointers=0, err_q=0.
  - Outputs are combinational from this state, so after reset: outstanding_o=0, err_o=0, vld_o=0.
  - req_o and gnt_o are 0 unless req_i is set.
  - Reset mid-operation discards all in-flight IDs; later vld_i pulses set err_o.
- full = (count_q == MaxOutstanding), computed from registered state only. No same-cycle pop bypass.
- Arbitration (combinational, zero latency):
  - winner = first index i with req_i[i]=1, searching rr_ptr_q, rr_ptr_q+1, … with wrap modulo NumIn.
  - req_o = |req_i & ~full.
  - data_o = data_i[winner]; when req_o=0, data_o = data_i[rr_ptr_q].
  - gnt_o[winner] = req_o & gnt_i; all other gnt_o bits are 0.
- Accept event (req_o & gnt_i), effective at the next posedge:
  - push winner into the FIFO.
  - rr_ptr_q <= (winner+1) mod NumIn. Non-power-of-two NumIn wraps explicitly.
  - rr_ptr_q is unchanged when there is no accept; a bank stall (gnt_i=0) does not rotate priority.
- Response (combinational, zero latency):
  - If vld_i & (count_q != 0): vld_o[fifo_head]=1 and pop at the next posedge.
  - If vld_i & (count_q == 0): vld_o=0 and err_q <= 1, held until reset.
  - rdata_o[i] = rdata_i for all i, regardless of vld.
- Simultaneous accept and response:
  - Push and pop in the same cycle; count unchanged.
  - A response in the accept cycle belongs to the older head entry, never to the one being pushed.
- When full, requests are back-pressured (req_o=0, gnt_o=0) even if a pop occurs in the same cycle. A request is granted the cycle after the count drops.
- NumIn==1: winner=0, rr_ptr_q is constant 0, and the FIFO still tracks occupancy.
- Masters keep req_i/data_i stable until granted; the block adds no request buffering.

Test Plan:
- Single request: NumIn=4, req_i=4'b0100, gnt_i=1 → gnt_o=4'b0100 in the same cycle, data_o=data_i[2], outstanding_o=1 next cycle. Then vld_i=1, rdata_i=32'hDEAD_BEEF two cycles later → vld_o=4'b0100, rdata_o[2]=32'hDEAD_BEEF, outstanding_o=0.
- Round-robin fairness: req_i=4'b1111 held with gnt_i=1 and vld_i=1 every cycle after the first accept → grant order 0,1,2,3,0; each vld_o matches the master granted one cycle earlier.
- Bank stall: req_i=4'b0011, gnt_i=0 for 3 cycles → gnt_o=0 and rr_ptr_q stays 0. Then gnt_i=1 → master 0 is granted first.
- Back-pressure: MaxOutstanding=2, two accepts with no vld_i → outstanding_o=2, req_o=0, gnt_o=0. Then vld_i=1 → vld_o targets the first ID, req_o stays 0 that cycle and becomes 1 the next cycle.
- Spurious response: vld_i=1 with outstanding_o=0 → vld_o=0 and err_o=1 from the next cycle until reset. Then rst_i=1 for 1 cycle → err_o=0, outstanding_o=0.
- Reset mid-flight: two accepted (outstanding_o=2), assert rst_i → outstanding_o=0 and rr_ptr_q=0. A subsequent vld_i sets err_o=1.

Source files
------------

// File: rtl/tcdm_bank_arbiter_varlat.sv
// tcdm_bank_arbiter_varlat
//
// Purpose:
//   Slave-side arbiter of the variable-latency TCDM crossbar. NumIn masters
//   share one bank that may answer after an arbitrary number of cycles.
//   Requests are picked round-robin. The ID of every accepted request is
//   queued in order, so each bank response can be steered back to its master.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   req_i, data_i  per-master request and payload (data_i is packed, master 0 in the LSBs)
//   gnt_o          per-master grant, one-hot or zero
//   vld_o          per-master response valid, one-hot or zero
//   rdata_o        bank response data replicated for every master
//   req_o, data_o  request and payload towards the bank
//   gnt_i          bank grant
//   vld_i          bank response valid (in order)
//   rdata_i        bank response data
//   outstanding_o  number of accepted but unanswered transactions
//   err_o          sticky flag: response arrived with nothing outstanding
module tcdm_bank_arbiter_varlat #(
  parameter int NumIn          = 4,
  parameter int ReqDataWidth   = 32,
  parameter int RespDataWidth  = 32,
  parameter int MaxOutstanding = 2,
  parameter int LogNumIn       = (NumIn > 1) ? $clog2(NumIn) : 1,
  parameter int CntWidth       = $clog2(MaxOutstanding + 1),
  parameter int PtrWidth       = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumIn-1:0]                 req_i,
  input  logic [NumIn*ReqDataWidth-1:0]    data_i,
  output logic [NumIn-1:0]                 gnt_o,
  output logic [NumIn-1:0]                 vld_o,
  output logic [NumIn*RespDataWidth-1:0]   rdata_o,
  output logic                             req_o,
  output logic [ReqDataWidth-1:0]          data_o,
  input  logic                             gnt_i,
  input  logic                             vld_i,
  input  logic [RespDataWidth-1:0]         rdata_i,
  output logic [CntWidth-1:0]              outstanding_o,
  output logic                             err_o
);

  logic [LogNumIn-1:0] r_rrPtr;
  logic [LogNumIn-1:0] r_fifo [MaxOutstanding];
  logic [PtrWidth-1:0] r_wrPtr;
  logic [PtrWidth-1:0] r_rdPtr;
  logic [CntWidth-1:0] r_count;
  logic                r_err;

  logic [LogNumIn-1:0] w_winner;
  logic                w_found;
  logic                w_full;
  logic                w_accept;
  logic                w_pop;
  logic [LogNumIn-1:0] w_head;
  logic [LogNumIn-1:0] w_sel;

  // Fullness looks at registered occupancy only; a pop in the same cycle
  // does not free a slot until the next cycle.
  assign w_full   = (r_count == CntWidth'(MaxOutstanding));
  assign req_o    = (|req_i) & ~w_full;
  assign w_accept = req_o & gnt_i;
  assign w_pop    = vld_i & (r_count != '0);
  assign w_head   = r_fifo[r_rdPtr];
  assign w_sel    = req_o ? w_winner : r_rrPtr;

  assign outstanding_o = r_count;
  assign err_o         = r_err;
  assign rdata_o       = {NumIn{rdata_i}};

  // Round-robin search starting at the priority pointer, wrapping modulo
  // NumIn so that non-power-of-two master counts work.
  always_comb begin
    int idx;
    idx      = 0;
    w_winner = r_rrPtr;
    w_found  = 1'b0;
    for (int k = 0; k < NumIn; k++) begin
      idx = int'(r_rrPtr) + k;
      if (idx >= NumIn) idx = idx - NumIn;
      if (!w_found && req_i[idx]) begin
        w_found  = 1'b1;
        w_winner = LogNumIn'(idx);
      end
    end
  end

  // Payload mux; with no forwarded request it shows the priority master.
  always_comb begin
    data_o = data_i[ReqDataWidth-1:0];
    for (int i = 0; i < NumIn; i++) begin
      if (w_sel == LogNumIn'(i)) data_o = data_i[i*ReqDataWidth +: ReqDataWidth];
    end
  end

  // Grant goes to the winner only when the bank takes the request; the
  // response valid goes to the master at the head of the ID queue.
  always_comb begin
    gnt_o = '0;
    vld_o = '0;
    for (int i = 0; i < NumIn; i++) begin
      if (w_accept && (w_winner == LogNumIn'(i))) gnt_o[i] = 1'b1;
      if (w_pop && (w_head == LogNumIn'(i)))      vld_o[i] = 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk_i) begin
    if (w_accept) r_fifo[r_wrPtr] <= w_winner;
  end

  // Control state: priority pointer, queue pointers, occupancy and the
  // sticky error. The pointer rotates past the winner only on an accept,
  // so a stalled bank keeps the current priority order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rrPtr <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rrPtr <= (w_winner == LogNumIn'(NumIn - 1)) ? '0 : w_winner + 1'b1;
        r_wrPtr <= (r_wrPtr == PtrWidth'(MaxOutstanding - 1)) ? '0 : r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == PtrWidth'(MaxOutstanding - 1)) ? '0 : r_rdPtr + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (vld_i && (r_count == '0)) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tcdm_bank_arbiter_varlat.sv
// Testbench for tcdm_bank_arbiter_varlat with default parameters.
// A queue-based reference model predicts every output from the arbitration
// and response rules; directed scenarios are followed by random traffic.
module tb_tcdm_bank_arbiter_varlat;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MO = 2;

  logic            clk_i;
  logic            rst_i;
  logic [N-1:0]    req_i;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    vld_o;
  logic [N*DW-1:0] rdata_o;
  logic            req_o;
  logic [DW-1:0]   data_o;
  logic            gnt_i;
  logic            vld_i;
  logic [DW-1:0]   rdata_i;
  logic [1:0]      outstanding_o;
  logic            err_o;

  int nVectors;
  int nMiscompares;

  // Reference model state
  int mRr;
  int mQ[$];
  bit mErr;

  tcdm_bank_arbiter_varlat dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
    .gnt_o(gnt_o), .vld_o(vld_o), .rdata_o(rdata_o), .req_o(req_o),
    .data_o(data_o), .gnt_i(gnt_i), .vld_i(vld_i), .rdata_i(rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // One comparison: counts it, and counts plus reports it when it differs.
  task automatic checkOutput(input string tag, input logic [DW*N-1:0] obs, input logic [DW*N-1:0] exp);
    nVectors++;
    assert (obs === exp)
    else begin
      nMiscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, checks every output against the model in
  // mid-cycle, then advances the model across the rising edge.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] req, input logic gnt,
                               input logic vld, input logic [DW-1:0] rdata);
    int win;
    bit found;
    bit full;
    bit expReq;
    int sel;
    logic [DW-1:0] words [N];
    logic [N-1:0] expGnt;
    logic [N-1:0] expVld;
    for (int i = 0; i < N; i++) words[i] = $urandom;
    rst_i   = rst;
    req_i   = req;
    gnt_i   = gnt;
    vld_i   = vld;
    rdata_i = rdata;
    for (int i = 0; i < N; i++) data_i[i*DW +: DW] = words[i];
    #2;
    win = 0;
    found = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(mRr + k) % N]) begin
        found = 1;
        win = (mRr + k) % N;
      end
    end
    full   = (mQ.size() == MO);
    expReq = found && !full;
    sel    = expReq ? win : mRr;
    expGnt = (expReq && gnt) ? N'(1 << win) : '0;
    expVld = (vld && mQ.size() > 0) ? N'(1 << mQ[0]) : '0;
    checkOutput("req_o", req_o, expReq);
    checkOutput("gnt_o", gnt_o, expGnt);
    checkOutput("data_o", data_o, words[sel]);
    checkOutput("vld_o", vld_o, expVld);
    checkOutput("rdata_o", rdata_o, {N{rdata}});
    checkOutput("outstanding_o", outstanding_o, mQ.size());
    checkOutput("err_o", err_o, mErr);
    @(posedge clk_i);
    if (rst) begin
      mRr = 0;
      mQ.delete();
      mErr = 0;
    end else begin
      if (vld && mQ.size() > 0) void'(mQ.pop_front());
      else if (vld) mErr = 1;
      if (expReq && gnt) begin
        mQ.push_back(win);
        mRr = (win + 1) % N;
      end
    end
    #1;
  endtask

  initial begin
    nVectors = 0;
    nMiscompares = 0;
    mRr = 0;
    mErr = 0;
    rst_i = 1'b1;
    req_i = '0;
    data_i = '0;
    gnt_i = 1'b0;
    vld_i = 1'b0;
    rdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset state
    applyStimulus(1, 4'b0000, 0, 0, 32'h0);
    checkOutput("resetOutstanding", outstanding_o, 0);
    checkOutput("resetErr", err_o, 0);

    // Single request from master 2, answered two cycles later
    applyStimulus(0, 4'b0100, 1, 0, 32'h0);
    checkOutput("singleOutstanding", outstanding_o, 1);
    applyStimulus(0, 4'b0000, 0, 0, 32'h0);
    applyStimulus(0, 4'b0000, 0, 1, 32'hDEAD_BEEF);
    checkOutput("singleDrained", outstanding_o, 0);

    // Round-robin with all masters requesting and the bank answering each cycle
    applyStimulus(1, 4'b0000, 0, 0, 32'h0);
    applyStimulus(0, 4'b1111, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 4'b1111, 1, 1, $urandom);
    applyStimulus(0, 4'b0000, 0, 1, $urandom);

    // Bank stall does not rotate priority
    applyStimulus(1, 4'b0000, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0011, 0, 0, 32'h0);
    applyStimulus(0, 4'b0011, 1, 0, 32'h0);

    // Back-pressure when the ID queue is full
    applyStimulus(1, 4'b0000, 0, 0, 32'h0);
    applyStimulus(0, 4'b1111, 1, 0, 32'h0);
    applyStimulus(0, 4'b1111, 1, 0, 32'h0);
    checkOutput("fullOutstanding", outstanding_o, 2);
    checkOutput("fullReqBlocked", req_o, 0);
    applyStimulus(0, 4'b1111, 1, 1, 32'h1234_5678);
    checkOutput("afterPopReq", req_o, 1);
    applyStimulus(0, 4'b1111, 1, 0, 32'h0);

    // Spurious response sets the sticky error, reset clears it
    applyStimulus(1, 4'b0000, 0, 0, 32'h0);
    applyStimulus(0, 4'b0000, 0, 1, 32'hAAAA_5555);
    checkOutput("spuriousErr", err_o, 1);
    applyStimulus(0, 4'b0000, 0, 0, 32'h0);
    checkOutput("errHeld", err_o, 1);
    applyStimulus(1, 4'b0000, 0, 0, 32'h0);
    checkOutput("errCleared", err_o, 0);

    // Reset with two transactions in flight discards them
    applyStimulus(0, 4'b0110, 1, 0, 32'h0);
    applyStimulus(0, 4'b0110, 1, 0, 32'h0);
    checkOutput("midFlightOutstanding", outstanding_o, 2);
    applyStimulus(1, 4'b0000, 0, 0, 32'h0);
    checkOutput("midFlightReset", outstanding_o, 0);
    applyStimulus(0, 4'b0000, 0, 1, 32'h0);
    checkOutput("midFlightErr", err_o, 1);
    applyStimulus(1, 4'b0000, 0, 0, 32'h0);

    // Random traffic with occasional resets
    for (int c = 0; c < 500; c++) begin
      applyStimulus(($urandom_range(0, 59) == 0), N'($urandom), 1'($urandom),
                    ($urandom_range(0, 2) == 0), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
